nmr_alu: RTL and testbench
==========================

Name: nmr_alu

Overview:
- Parametrised N-modular-redundant ALU: R identical `alu` replicas, a registered majority voter and per-replica fault tracking.
- Replicas that repeatedly disagree are excluded from the vote. The block reports health to the SoC monitoring logic.
- Drop-in successor to the fixed 5-way redundant ALU in the execute stage. Differences: one cycle of latency, a valid handshake, and a fault-injection port for radiation-campaign testing.

Parameters:
- N, 64: operand/result width.
- R, 5: replica count; odd, 3..7. Other values are illegal (elaboration $error).
- FAULT_THRESH, 3: consecutive mismatching votes before a replica is excluded; 1..15.
- CW, $clog2(FAULT_THRESH+1): per-replica miss-counter width (derived; do not override).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  operands valid this cycle.
- a, b  in  N  operands.
- wArith  in  1  word-arithmetic mode, passed to every replica.
- ALUControl  in  4  ALU operation, passed to every replica.
- inject_en  in  1  enable fault injection this cycle.
- inject_sel  in  3  replica index to corrupt (values ≥R ignored).
- inject_mask  in  N  XORed onto the selected replica's result.
- clear_faults  in  1  clear all exclusions and counters.
- valid_out  out  1  voted outputs valid.
- result  out  N  voted result.
- zero, overflow, sign  out  1 each  voted flags.
- disagree  out  1  at least one active replica differed from the vote.
- no_majority  out  1  no strict majority existed.
- replica_excluded  out  R  sticky exclusion mask.
- miss_count  out  R*CW  packed consecutive-miss counters; replica i at [i*CW +: CW].
- total_mismatch  out  16  saturating count of votes with disagree=1.
- health  out  2  00 HEALTHY, 01 DEGRADED, 10 CRITICAL.

Behaviour:
- Reset values: every output is 0, health=HEALTHY, and all counters and masks are 0.
- Replicas are combinational on the unregistered inputs.
- Injection:
  - Applies only when valid_in & inject_en & inject_sel<R.
  - XOR affects the result only, not the flags.
- Replica tuple: {result, zero, overflow, sign}.
- Active set: replicas with replica_excluded=0; A = active count (always ≥3).
- Vote:
  - For each active replica, count active replicas with an identical tuple, including itself.
  - The winner is the lowest-index replica with count > A/2 (integer divide).
  - If none exists: no_majority=1 and outputs take the lowest-index active replica.
- Latency: exactly 1 cycle.
  - On a valid_in cycle, outputs, disagree and no_majority register at the next edge, with valid_out=1.
  - On a cycle without valid_in: valid_out=0, data outputs hold, disagree=no_majority=0.
  - There is no back-pressure; a new operation is accepted every cycle.
- Fault update: only on a valid vote with a majority.
  - Active replica differing from the winner: its counter increments, saturating at FAULT_THRESH.
  - Active replica matching the winner: its counter clears to 0.
  - A counter reaching FAULT_THRESH sets replica_excluded in the same update, but only if A would remain ≥3.
  - Otherwise the counter holds at FAULT_THRESH, the replica stays active and health is set to CRITICAL.
  - If several replicas reach the threshold in the same cycle, exclude in ascending index while A ≥ 3.
- On a no_majority vote: counters unchanged, total_mismatch increments.
- Excluded replicas: counters frozen; they never vote and never cause disagree.
- total_mismatch: +1 per valid vote with disagree or no_majority; saturates at 0xFFFF.
- Health FSM, registered:
  - HEALTHY→DEGRADED when any exclusion occurs.
  - Any state→CRITICAL when A=3 and any active counter equals FAULT_THRESH, or when a no_majority vote occurs.
  - Leaving DEGRADED or CRITICAL happens only through clear_faults or reset.
- Priority is reset > clear_faults > fault update.
  - With clear_faults and valid_in together, that vote uses the pre-clear active set and is still output.
  - Counters, masks, total_mismatch and health clear at the same edge.
- Reset mid-operation discards the pending vote (valid_out=0 next cycle).

Test Plan:
- R=5, N=64, ADD 5+7, no injection → next cycle: valid_out=1, result=12, disagree=0, no_majority=0, health=00, all miss_count=0.
- Inject replica 2, mask=1, three consecutive valid ops → result stays correct each cycle, disagree=1, miss_count[2] = 1, 2, 3; replica_excluded=5'b00100 after the third; health=01.
- After that exclusion, one more op injecting replica 2 → disagree=0, total_mismatch unchanged (remains 3).
- Exclude replicas 2 and 3 (A=3), then inject replica 4 three times → replica 4 not excluded, miss_count[4]=3, health=10, result correct.
- R=3, inject replicas 0 and 1 in the same cycle with different masks → no_majority=1, result = replica 0 value, health=10, counters unchanged.
- valid_in and clear_faults asserted together while in DEGRADED → that cycle's vote is output with the old mask; next cycle replica_excluded=0, total_mismatch=0, health=00. Reset asserted during a valid cycle → valid_out=0 next cycle.

Source files
------------

// File: rtl/nmr_alu.sv
// nmr_alu: R-way redundant ALU with a 1-cycle majority voter, per-replica miss counters, exclusion, and a health FSM.
module alu #(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         wArith,
  input  logic [3:0]   ALUControl,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         overflow,
  output logic         sign
);
  localparam int H = N / 2;
  localparam int SW = $clog2(N);
  logic [N-1:0] ua, ub, sa, sb, sum, dif, r;
  logic [SW-1:0] sh;
  logic m_a, m_b, m_s, m_d;
  always_comb begin
    ua = wArith ? {{(N-H){1'b0}}, a[H-1:0]} : a;
    ub = wArith ? {{(N-H){1'b0}}, b[H-1:0]} : b;
    sa = wArith ? {{(N-H){a[H-1]}}, a[H-1:0]} : a;
    sb = wArith ? {{(N-H){b[H-1]}}, b[H-1:0]} : b;
    sh = wArith ? {1'b0, b[SW-2:0]} : b[SW-1:0];
    sum = a + b;
    dif = a - b;
    m_a = wArith ? a[H-1] : a[N-1];
    m_b = wArith ? b[H-1] : b[N-1];
    m_s = wArith ? sum[H-1] : sum[N-1];
    m_d = wArith ? dif[H-1] : dif[N-1];
    case (ALUControl)
      4'd0: r = sum;
      4'd1: r = dif;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << sh;
      4'd6: r = ua >> sh;
      4'd7: r = $signed(sa) >>> sh;
      4'd8: r = {{(N-1){1'b0}}, $signed(sa) < $signed(sb)};
      4'd9: r = {{(N-1){1'b0}}, ua < ub};
      default: r = '0;
    endcase
    result = wArith ? {{(N-H){r[H-1]}}, r[H-1:0]} : r;
    overflow = ALUControl == 4'd0 ? (m_a == m_b && m_s != m_a) :
               ALUControl == 4'd1 ? (m_a != m_b && m_d != m_a) : 1'b0;
    zero = result == '0;
    sign = result[N-1];
  end
endmodule

module nmr_alu #(
  parameter int N = 64,
  parameter int R = 5,
  parameter int FAULT_THRESH = 3,
  parameter int CW = $clog2(FAULT_THRESH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [N-1:0]    a,
  input  logic [N-1:0]    b,
  input  logic            wArith,
  input  logic [3:0]      ALUControl,
  input  logic            inject_en,
  input  logic [2:0]      inject_sel,
  input  logic [N-1:0]    inject_mask,
  input  logic            clear_faults,
  output logic            valid_out,
  output logic [N-1:0]    result,
  output logic            zero,
  output logic            overflow,
  output logic            sign,
  output logic            disagree,
  output logic            no_majority,
  output logic [R-1:0]    replica_excluded,
  output logic [R*CW-1:0] miss_count,
  output logic [15:0]     total_mismatch,
  output logic [1:0]      health
);
  localparam logic [CW-1:0] FT = CW'(FAULT_THRESH);
  typedef enum logic [1:0] {HEALTHY = 2'd0, DEGRADED = 2'd1, CRITICAL = 2'd2} health_t;
  health_t st, st_n;
  logic [N+2:0] tup [R];
  logic [N+2:0] vt;
  logic [R-1:0] excl, excl_n;
  logic [R-1:0][CW-1:0] miss, miss_n;
  logic found, dis, crit;
  int act, win, first, left;
  int cnt [R];
  genvar i;
  generate
    if (R < 3 || R > 7 || R % 2 == 0) $error("nmr_alu: R must be odd and within 3..7");
    if (FAULT_THRESH < 1 || FAULT_THRESH > 15) $error("nmr_alu: FAULT_THRESH must be within 1..15");
    for (i = 0; i < R; i++) begin : g_rep
      logic [N-1:0] raw, r;
      logic z, o, s;
      alu #(.N(N)) u_alu (
        .a(a), .b(b), .wArith(wArith), .ALUControl(ALUControl),
        .result(raw), .zero(z), .overflow(o), .sign(s)
      );
      assign r = raw ^ ((valid_in && inject_en && inject_sel == 3'(i)) ? inject_mask : '0);
      assign tup[i] = {r, z, o, s};
    end
  endgenerate
  always_comb begin
    act = 0;
    first = 0;
    win = 0;
    found = 1'b0;
    dis = 1'b0;
    for (int j = 0; j < R; j++) act += excl[j] ? 0 : 1;
    for (int j = R - 1; j >= 0; j--) first = excl[j] ? first : j;
    for (int j = 0; j < R; j++) begin
      cnt[j] = 0;
      for (int k = 0; k < R; k++) cnt[j] += (!excl[j] && !excl[k] && tup[j] == tup[k]) ? 1 : 0;
    end
    for (int j = R - 1; j >= 0; j--)
      if (cnt[j] > act / 2) begin
        win = j;
        found = 1'b1;
      end
    vt = tup[found ? win : first];
    for (int j = 0; j < R; j++) dis |= !excl[j] && tup[j] != vt;
    left = act;
    crit = 1'b0;
    excl_n = excl;
    miss_n = miss;
    for (int j = 0; j < R; j++)
      if (valid_in && found && !excl[j]) begin
        miss_n[j] = tup[j] == vt ? '0 : miss[j] == FT ? FT : miss[j] + 1'b1;
        if (miss_n[j] == FT && left > 3) begin
          excl_n[j] = 1'b1;
          left--;
        end else if (miss_n[j] == FT) crit = 1'b1;
      end
    st_n = (crit || (valid_in && !found)) ? CRITICAL :
           (excl_n != excl && st == HEALTHY) ? DEGRADED : st;
  end
  always_ff @(posedge clk)
    if (reset) begin
      valid_out <= 1'b0;
      {result, zero, overflow, sign} <= '0;
      disagree <= 1'b0;
      no_majority <= 1'b0;
      excl <= '0;
      miss <= '0;
      total_mismatch <= '0;
      st <= HEALTHY;
    end else begin
      valid_out <= valid_in;
      disagree <= valid_in && dis;
      no_majority <= valid_in && !found;
      if (valid_in) {result, zero, overflow, sign} <= vt;
      if (clear_faults) begin
        excl <= '0;
        miss <= '0;
        total_mismatch <= '0;
        st <= HEALTHY;
      end else begin
        excl <= excl_n;
        miss <= miss_n;
        st <= st_n;
        if (valid_in && (dis || !found) && total_mismatch != 16'hFFFF) total_mismatch <= total_mismatch + 1'b1;
      end
    end
  assign replica_excluded = excl;
  assign miss_count = miss;
  assign health = st;
endmodule

// File: tb/tb_nmr_alu.sv
// tb_nmr_alu: table-driven check of nmr_alu voting, exclusion, health and clear/reset behaviour.
module tb_nmr_alu;
  logic clk = 0, reset = 1, valid_in = 0, wArith = 0, inject_en = 0, clear_faults = 0;
  logic [63:0] a = 0, b = 0, inject_mask = 0;
  logic [3:0] ALUControl = 0;
  logic [2:0] inject_sel = 0;
  logic valid_out, zero, overflow, sign, disagree, no_majority;
  logic [63:0] result;
  logic [4:0] replica_excluded;
  logic [9:0] miss_count;
  logic [15:0] total_mismatch;
  logic [1:0] health;
  logic valid3 = 0, inj3 = 0;
  logic [63:0] mask3 = 0;
  logic [2:0] sel3 = 0;
  logic v3_out, z3, o3, s3, d3, nm3;
  logic [63:0] res3;
  logic [2:0] ex3;
  logic [5:0] mc3;
  logic [15:0] tm3;
  logic [1:0] h3;
  int total = 0, bad = 0;
  typedef struct {
    logic [3:0] op; logic w; logic [63:0] a, b; logic ie; logic [2:0] is; logic [63:0] m; logic clr;
    logic [63:0] res; logic [2:0] fl; logic dis, nm; logic [4:0] ex; logic [9:0] mc; logic [15:0] tm; logic [1:0] h;
  } vec_t;
  vec_t v [20];

  always #5 clk = ~clk;

  nmr_alu #(.N(64), .R(5), .FAULT_THRESH(3)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .a(a), .b(b), .wArith(wArith), .ALUControl(ALUControl),
    .inject_en(inject_en), .inject_sel(inject_sel), .inject_mask(inject_mask), .clear_faults(clear_faults),
    .valid_out(valid_out), .result(result), .zero(zero), .overflow(overflow), .sign(sign),
    .disagree(disagree), .no_majority(no_majority), .replica_excluded(replica_excluded),
    .miss_count(miss_count), .total_mismatch(total_mismatch), .health(health)
  );

  nmr_alu #(.N(64), .R(3), .FAULT_THRESH(3)) dut3 (
    .clk(clk), .reset(reset), .valid_in(valid3), .a(a), .b(b), .wArith(wArith), .ALUControl(ALUControl),
    .inject_en(inj3), .inject_sel(sel3), .inject_mask(mask3), .clear_faults(1'b0),
    .valid_out(v3_out), .result(res3), .zero(z3), .overflow(o3), .sign(s3),
    .disagree(d3), .no_majority(nm3), .replica_excluded(ex3),
    .miss_count(mc3), .total_mismatch(tm3), .health(h3)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  initial begin
    v[0]  = '{0, 0, 5, 7, 0, 0, 0, 0, 12, 3'b000, 0, 0, 5'h00, 10'h000, 0, 0};
    v[1]  = '{0, 0, 5, 7, 1, 2, 1, 0, 12, 3'b000, 1, 0, 5'h00, 10'h010, 1, 0};
    v[2]  = '{1, 0, 10, 3, 1, 2, 1, 0, 7, 3'b000, 1, 0, 5'h00, 10'h020, 2, 0};
    v[3]  = '{2, 0, 64'hff, 64'h0f, 1, 2, 1, 0, 64'h0f, 3'b000, 1, 0, 5'h04, 10'h030, 3, 1};
    v[4]  = '{3, 0, 64'hf0, 64'h0f, 1, 2, 1, 0, 64'hff, 3'b000, 0, 0, 5'h04, 10'h030, 3, 1};
    v[5]  = '{4, 0, 5, 5, 1, 3, 2, 0, 0, 3'b100, 1, 0, 5'h04, 10'h070, 4, 1};
    v[6]  = '{0, 0, 64'h7fff_ffff_ffff_ffff, 1, 1, 3, 2, 0, 64'h8000_0000_0000_0000, 3'b011, 1, 0, 5'h04, 10'h0b0, 5, 1};
    v[7]  = '{1, 0, 0, 1, 1, 3, 2, 0, 64'hffff_ffff_ffff_ffff, 3'b001, 1, 0, 5'h0c, 10'h0f0, 6, 1};
    v[8]  = '{0, 0, 1, 1, 1, 4, 8, 0, 2, 3'b000, 1, 0, 5'h0c, 10'h1f0, 7, 1};
    v[9]  = '{0, 0, 1, 1, 1, 4, 8, 0, 2, 3'b000, 1, 0, 5'h0c, 10'h2f0, 8, 1};
    v[10] = '{0, 0, 1, 1, 1, 4, 8, 0, 2, 3'b000, 1, 0, 5'h0c, 10'h3f0, 9, 2};
    v[11] = '{0, 0, 1, 1, 1, 4, 8, 0, 2, 3'b000, 1, 0, 5'h0c, 10'h3f0, 10, 2};
    v[12] = '{0, 0, 2, 3, 0, 0, 0, 0, 5, 3'b000, 0, 0, 5'h0c, 10'h0f0, 10, 2};
    v[13] = '{0, 1, 64'h7fff_ffff, 1, 1, 7, 64'hff, 0, 64'hffff_ffff_8000_0000, 3'b011, 0, 0, 5'h0c, 10'h0f0, 10, 2};
    v[14] = '{0, 0, 3, 4, 1, 2, 1, 1, 7, 3'b000, 0, 0, 5'h00, 10'h000, 0, 0};
    v[15] = '{0, 0, 1, 2, 1, 0, 4, 0, 3, 3'b000, 1, 0, 5'h00, 10'h001, 1, 0};
    v[16] = '{0, 0, 1, 2, 1, 0, 4, 0, 3, 3'b000, 1, 0, 5'h00, 10'h002, 2, 0};
    v[17] = '{0, 0, 1, 2, 1, 0, 4, 0, 3, 3'b000, 1, 0, 5'h01, 10'h003, 3, 1};
    v[18] = '{0, 0, 4, 4, 1, 0, 4, 1, 8, 3'b000, 0, 0, 5'h00, 10'h000, 0, 0};
    v[19] = '{2, 0, 64'hf0, 64'h3c, 0, 0, 0, 0, 64'h30, 3'b000, 0, 0, 5'h00, 10'h000, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(valid_out), 0);
    chk("rst_result", result, 0);
    chk("rst_flags", 64'({zero, overflow, sign, disagree, no_majority}), 0);
    chk("rst_excl", 64'(replica_excluded), 0);
    chk("rst_miss", 64'(miss_count), 0);
    chk("rst_tm", 64'(total_mismatch), 0);
    chk("rst_health", 64'(health), 0);
    chk("rst3_health", 64'(h3), 0);
    reset = 0;
    for (int i = 0; i < 20; i++) begin
      ALUControl = v[i].op; wArith = v[i].w; a = v[i].a; b = v[i].b;
      inject_en = v[i].ie; inject_sel = v[i].is; inject_mask = v[i].m; clear_faults = v[i].clr;
      valid_in = 1;
      @(posedge clk);
      #1;
      chk($sformatf("valid[%0d]", i), 64'(valid_out), 1);
      chk($sformatf("result[%0d]", i), result, v[i].res);
      chk($sformatf("flags[%0d]", i), 64'({zero, overflow, sign}), 64'(v[i].fl));
      chk($sformatf("disagree[%0d]", i), 64'(disagree), 64'(v[i].dis));
      chk($sformatf("no_majority[%0d]", i), 64'(no_majority), 64'(v[i].nm));
      chk($sformatf("excluded[%0d]", i), 64'(replica_excluded), 64'(v[i].ex));
      chk($sformatf("miss_count[%0d]", i), 64'(miss_count), 64'(v[i].mc));
      chk($sformatf("total_mismatch[%0d]", i), 64'(total_mismatch), 64'(v[i].tm));
      chk($sformatf("health[%0d]", i), 64'(health), 64'(v[i].h));
    end
    valid_in = 0; inject_en = 0; clear_faults = 0; wArith = 0;
    ALUControl = 0; a = 100; b = 100;
    @(posedge clk);
    #1;
    chk("idle_valid", 64'(valid_out), 0);
    chk("idle_hold_result", result, 64'h30);
    chk("idle_disagree", 64'(disagree), 0);
    valid_in = 1; a = 9; b = 9; reset = 1;
    @(posedge clk);
    #1;
    reset = 0; valid_in = 0;
    chk("midrst_valid", 64'(valid_out), 0);
    chk("midrst_result", result, 0);
    a = 5; b = 7; ALUControl = 0;
    valid3 = 1; inj3 = 1; sel3 = 0; mask3 = 1;
    force dut3.g_rep[1].r = 64'd14;
    @(posedge clk);
    #1;
    valid3 = 0; inj3 = 0;
    release dut3.g_rep[1].r;
    chk("nomaj_valid", 64'(v3_out), 1);
    chk("nomaj_flag", 64'(nm3), 1);
    chk("nomaj_result", res3, 64'd13);
    chk("nomaj_disagree", 64'(d3), 1);
    chk("nomaj_health", 64'(h3), 2);
    chk("nomaj_miss", 64'(mc3), 0);
    chk("nomaj_excl", 64'(ex3), 0);
    chk("nomaj_tm", 64'(tm3), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
